// File: rtl/c499_sec_encoder_pipe.sv
// Two-stage check-bit generator for the 32-bit c499 SEC code, valid/ready on both sides.
// Stage 1 registers group/column parities; stage 2 folds them into check bits and applies error injection.
module c499_sec_encoder_pipe #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          inj_en,
  input  logic [4:0]    inj_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_check,
  output logic [15:0]   word_cnt
);

  if (DW != 32) begin : g_bad_dw
    $error("c499_sec_encoder_pipe: DW must be 32");
  end
  if (CW != 8) begin : g_bad_cw
    $error("c499_sec_encoder_pipe: CW must be 8");
  end

  // Dg[j]: parity of nibble j.
  function automatic logic [7:0] grp_par(input logic [31:0] d);
    logic [7:0] g;
    for (int j = 0; j < 8; j++) g[j] = ^d[4*j +: 4];
    return g;
  endfunction

  // Dc[m] (m<4): parity of bits m,m+4,m+8,m+12; Dc[4+m]: same pattern in the upper half.
  function automatic logic [7:0] col_par(input logic [31:0] d);
    logic [7:0] c;
    for (int m = 0; m < 4; m++) begin
      c[m]   = d[m]      ^ d[m + 4]  ^ d[m + 8]  ^ d[m + 12];
      c[4+m] = d[16 + m] ^ d[20 + m] ^ d[24 + m] ^ d[28 + m];
    end
    return c;
  endfunction

  function automatic logic [7:0] fold_check(input logic [7:0] dg, input logic [7:0] dc);
    logic [7:0] c;
    c[0] = dg[4] ^ dg[5] ^ dc[0];
    c[1] = dg[6] ^ dg[7] ^ dc[1];
    c[2] = dg[4] ^ dg[6] ^ dc[2];
    c[3] = dg[5] ^ dg[7] ^ dc[3];
    c[4] = dg[0] ^ dg[1] ^ dc[4];
    c[5] = dg[2] ^ dg[3] ^ dc[5];
    c[6] = dg[0] ^ dg[2] ^ dc[6];
    c[7] = dg[1] ^ dg[3] ^ dc[7];
    return c;
  endfunction

  logic          vld_p1, vld_p2;
  logic [31:0]   data_p1;
  logic          inj_en_p1;
  logic [4:0]    inj_sel_p1;
  logic [7:0]    dg_p1, dc_p1;
  logic [31:0]   data_p2;
  logic [7:0]    check_p2;
  logic [15:0]   cnt;
  logic          adv1, adv2, acc;

  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;
  assign acc      = in_valid && adv1;

  // Stage 1: capture word and its parities
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      inj_en_p1  <= 1'b0;
      inj_sel_p1 <= '0;
      dg_p1      <= '0;
      dc_p1      <= '0;
    end else if (adv1) begin
      vld_p1 <= acc;
      if (acc) begin
        data_p1    <= in_data;
        inj_en_p1  <= inj_en;
        inj_sel_p1 <= inj_sel;
        dg_p1      <= grp_par(in_data);
        dc_p1      <= col_par(in_data);
      end
    end
  end

  // Stage 2: check bits from clean data, injection only on the data path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      data_p2  <= '0;
      check_p2 <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2  <= data_p1 ^ ({31'b0, inj_en_p1} << inj_sel_p1);
        check_p2 <= fold_check(dg_p1, dc_p1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (vld_p2 && out_ready) cnt <= cnt + 16'd1;
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_check = check_p2;
  assign word_cnt  = cnt;

endmodule

// File: tb/tb_c499_sec_encoder_pipe.sv
// Scoreboard bench for c499_sec_encoder_pipe: a parity-mask reference encoder and a
// syndrome-lookup c499 corrector predict every output word.
module tb_c499_sec_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        inj_en = 1'b0;
  logic [4:0]  inj_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic [15:0] word_cnt;

  c499_sec_encoder_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inj_en(inj_en), .inj_sel(inj_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_check(out_check), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int stalls = 0;
  logic rdy_rand = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
    logic [31:0] clean;
  } exp_t;
  exp_t q[$];
  logic [15:0] hs_cnt = '0;

  // Each check bit covers the data bits set in its mask.
  logic [31:0] cmask [8] = '{32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
                             32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0};

  function automatic logic [7:0] enc(input logic [31:0] d);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) c[k] = ^(d & cmask[k]);
    return c;
  endfunction

  function automatic logic [31:0] c499(input logic [31:0] d, input logic [7:0] c);
    logic [7:0] s, col;
    logic [31:0] r;
    s = c ^ enc(d);
    r = d;
    if (s != 8'h00)
      for (int i = 0; i < 32; i++) begin
        for (int k = 0; k < 8; k++) col[k] = cmask[k][i];
        if (col == s) r = d ^ (32'h1 << i);
      end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  logic        held = 1'b0;
  logic [31:0] held_d;
  logic [7:0]  held_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
      hs_cnt = '0;
    end else begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !(q.size() == 2 && !out_ready)});
      if (held) begin
        chk("stall_valid", {31'b0, out_valid}, 32'h1);
        chk("stall_data", out_data, held_d);
        chk("stall_check", {24'b0, out_check}, {24'b0, held_c});
      end
      held = out_valid && !out_ready;
      held_d = out_data;
      held_c = out_check;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'h1, 32'h0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_check", {24'b0, out_check}, {24'b0, e.c});
          chk("c499_corrects", c499(out_data, out_check), e.clean);
        end
        hs_cnt = hs_cnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.clean = in_data;
        e.c = enc(in_data);
        e.d = in_data ^ (inj_en ? (32'h1 << inj_sel) : 32'h0);
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 99) >= 30);
  end

  task automatic send(input logic [31:0] d, input logic ie, input logic [4:0] is);
    int k;
    in_valid = 1'b1; in_data = d; inj_en = ie; inj_sel = is;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      stalls++; k++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'h1, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input logic [31:0] d, input logic ie, input logic [4:0] is,
                          input logic [31:0] exp_d, input logic [7:0] exp_c);
    send(d, ie, is);
    @(negedge clk);
    chk("lat_early", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    chk("lat_valid", {31'b0, out_valid}, 32'h1);
    chk("dir_data", out_data, exp_d);
    chk("dir_check", {24'b0, out_check}, {24'b0, exp_c});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      @(negedge clk); k++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_cnt", {16'b0, word_cnt}, 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_check", {24'b0, out_check}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();
    @(posedge clk); #1;

    // T1/T2/T5 directed
    directed(32'h00000000, 1'b0, 5'd0, 32'h00000000, 8'h00);
    directed(32'h00000001, 1'b0, 5'd0, 32'h00000001, 8'h51);
    directed(32'h80000000, 1'b0, 5'd0, 32'h80000000, 8'h8A);
    directed(32'hFFFFFFFF, 1'b0, 5'd0, 32'hFFFFFFFF, 8'h00);
    directed(32'h12345678, 1'b1, 5'd7, 32'h123456F8, enc(32'h12345678));

    // T3: back-to-back random, no backpressure
    do_reset();
    @(posedge clk); #1;
    stalls = 0;
    for (int i = 0; i < 1000; i++) send($urandom, 1'b0, 5'd0);
    drain();
    chk("t3_stalls", stalls, 0);
    chk("t3_word_cnt", {16'b0, word_cnt}, 32'd1000);

    // T4: random backpressure, gaps and injection
    rdy_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      send($urandom, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_word_cnt", {16'b0, word_cnt}, {16'b0, hs_cnt});
    @(posedge clk); #1;

    // T6: reset with two words in flight
    out_ready = 1'b0;
    send(32'hA5A5A5A5, 1'b0, 5'd0);
    send(32'h5A5A5A5A, 1'b0, 5'd0);
    chk("t6_full", {31'b0, out_valid}, 32'h1);
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    directed(32'hDEADBEEF, 1'b0, 5'd0, 32'hDEADBEEF, enc(32'hDEADBEEF));
    @(negedge clk);
    chk("t6_word_cnt", {16'b0, word_cnt}, 32'd1);
    chk("t6_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
